// File: rtl/ieee_operand_unpack_if.sv
// rtl/ieee_operand_unpack_if.sv - operand/result handshake bundle for the FP unpack stage
interface ieee_operand_unpack_if #(
    parameter int W     = 32,
    parameter int W_Exp = 8,
    parameter int W_Sgf = 23
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic             op_i;
    logic [W-1:0]     Data_X_i;
    logic [W-1:0]     Data_Y_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             sgn_M_o;
    logic             real_op_o;
    logic             x_gt_y_o;
    logic [W_Exp-1:0] exp_M_o;
    logic [W_Exp-1:0] exp_diff_o;
    logic [W_Sgf:0]   sgf_M_o;
    logic [W_Sgf:0]   sgf_m_o;
    logic             zero_o;
    logic             inf_o;
    logic             nan_o;

    modport slave (
        input  in_valid_i, op_i, Data_X_i, Data_Y_i, out_ready_i,
        output in_ready_o, out_valid_o, sgn_M_o, real_op_o, x_gt_y_o,
               exp_M_o, exp_diff_o, sgf_M_o, sgf_m_o, zero_o, inf_o, nan_o
    );

    modport master (
        output in_valid_i, op_i, Data_X_i, Data_Y_i, out_ready_i,
        input  in_ready_o, out_valid_o, sgn_M_o, real_op_o, x_gt_y_o,
               exp_M_o, exp_diff_o, sgf_M_o, sgf_m_o, zero_o, inf_o, nan_o
    );
endinterface

// File: rtl/ieee_operand_unpack.sv
// rtl/ieee_operand_unpack.sv - two-stage IEEE-754 operand unpack, classify and magnitude order
module ieee_operand_unpack #(
    parameter int W     = 32,
    parameter int W_Exp = 8,
    parameter int W_Sgf = 23
) (
    input  logic clk,
    input  logic rst,
    ieee_operand_unpack_if.slave bus
);
    typedef struct packed {
        logic             sgn_big;
        logic             real_op;
        logic             x_gt_y;
        logic [W_Exp-1:0] exp_big;
        logic [W_Exp-1:0] exp_diff;
        logic [W_Sgf:0]   sgf_big;
        logic [W_Sgf:0]   sgf_small;
        logic             zero;
        logic             inf;
        logic             nan;
    } s2_t;

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_x_q, s1_x_d;
    logic [W-1:0] s1_y_q, s1_y_d;
    logic         s1_op_q, s1_op_d;
    logic         s2_valid_q, s2_valid_d;
    s2_t          s2_q, s2_d;
    s2_t          unpacked;

    logic s2_free, in_ready, in_fire, s2_load;

    logic             sgn_x, sgn_y, sgn_y_eff;
    logic [W_Exp-1:0] exp_x, exp_y;
    logic [W_Sgf-1:0] frac_x_raw, frac_y_raw, frac_x, frac_y;
    logic             den_x, den_y, max_x, max_y;
    logic             nan_x, nan_y, inf_x, inf_y;
    logic [W_Exp-1:0] exp_small;

    assign sgn_x      = s1_x_q[W-1];
    assign sgn_y      = s1_y_q[W-1];
    assign exp_x      = s1_x_q[W-2 -: W_Exp];
    assign exp_y      = s1_y_q[W-2 -: W_Exp];
    assign frac_x_raw = s1_x_q[W_Sgf-1:0];
    assign frac_y_raw = s1_y_q[W_Sgf-1:0];

    // Denormals are flushed: zero exponent kills both the fraction and the hidden bit.
    assign den_x  = (exp_x == '0);
    assign den_y  = (exp_y == '0);
    assign max_x  = &exp_x;
    assign max_y  = &exp_y;
    assign frac_x = den_x ? '0 : frac_x_raw;
    assign frac_y = den_y ? '0 : frac_y_raw;
    assign nan_x  = max_x && (frac_x_raw != '0);
    assign nan_y  = max_y && (frac_y_raw != '0);
    assign inf_x  = max_x && (frac_x_raw == '0);
    assign inf_y  = max_y && (frac_y_raw == '0);

    assign sgn_y_eff = sgn_y ^ s1_op_q;

    always_comb begin
        unpacked          = '0;
        unpacked.x_gt_y   = ({exp_x, frac_x} >= {exp_y, frac_y});
        unpacked.real_op  = sgn_x ^ sgn_y_eff;
        unpacked.sgn_big  = unpacked.x_gt_y ? sgn_x : sgn_y_eff;
        unpacked.exp_big  = unpacked.x_gt_y ? exp_x : exp_y;
        exp_small         = unpacked.x_gt_y ? exp_y : exp_x;
        unpacked.exp_diff = unpacked.exp_big - exp_small;
        unpacked.sgf_big  = unpacked.x_gt_y ? {!den_x, frac_x} : {!den_y, frac_y};
        unpacked.sgf_small = unpacked.x_gt_y ? {!den_y, frac_y} : {!den_x, frac_x};
        // Inf - Inf under an effective subtract has no defined magnitude.
        unpacked.nan      = nan_x | nan_y | (inf_x & inf_y & unpacked.real_op);
        unpacked.inf      = !unpacked.nan & (inf_x | inf_y);
        unpacked.zero     = den_x & den_y;
    end

    assign s2_free  = !s2_valid_q | bus.out_ready_i;
    assign in_ready = !s1_valid_q | s2_free;
    assign in_fire  = bus.in_valid_i & in_ready;
    assign s2_load  = s1_valid_q & s2_free;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_op_d    = s1_op_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_x_d     = bus.Data_X_i;
            s1_y_d     = bus.Data_Y_i;
            s1_op_d    = bus.op_i;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_load | (s2_valid_q & !bus.out_ready_i);
        s2_d       = s2_load ? unpacked : s2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_op_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s2_valid_q;
    assign bus.sgn_M_o     = s2_q.sgn_big;
    assign bus.real_op_o   = s2_q.real_op;
    assign bus.x_gt_y_o    = s2_q.x_gt_y;
    assign bus.exp_M_o     = s2_q.exp_big;
    assign bus.exp_diff_o  = s2_q.exp_diff;
    assign bus.sgf_M_o     = s2_q.sgf_big;
    assign bus.sgf_m_o     = s2_q.sgf_small;
    assign bus.zero_o      = s2_q.zero;
    assign bus.inf_o       = s2_q.inf;
    assign bus.nan_o       = s2_q.nan;
endmodule

// File: tb/tb_ieee_operand_unpack.sv
// tb/tb_ieee_operand_unpack.sv - directed self-checking bench for ieee_operand_unpack
module tb_ieee_operand_unpack;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ieee_operand_unpack_if #(.W(32), .W_Exp(8), .W_Sgf(23)) bus ();

    ieee_operand_unpack #(.W(32), .W_Exp(8), .W_Sgf(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_stall = 0;
    int n_not_ready = 0;

    logic [79:0] exp_q[$];
    logic [31:0] vx[8];
    logic [31:0] vy[8];
    logic        vop[8];
    logic [79:0] vexp[8];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [79:0] mk(input logic sgn_m, input logic real_op, input logic xgt,
                                       input logic [7:0] exp_m, input logic [7:0] diff,
                                       input logic [23:0] sgf_big, input logic [23:0] sgf_small,
                                       input logic z, input logic i, input logic n);
        return {10'b0, sgn_m, real_op, xgt, exp_m, diff, sgf_big, sgf_small, z, i, n};
    endfunction

    function automatic logic [79:0] pack_out();
        return {10'b0, bus.sgn_M_o, bus.real_op_o, bus.x_gt_y_o, bus.exp_M_o, bus.exp_diff_o,
                bus.sgf_M_o, bus.sgf_m_o, bus.zero_o, bus.inf_o, bus.nan_o};
    endfunction

    // Output monitor: in-order scoreboard plus hold-while-stalled checks.
    logic        prev_stall = 1'b0;
    logic [79:0] prev_val   = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (!bus.in_ready_o) n_not_ready++;
            if (prev_stall) begin
                n_stall++;
                check("stall_valid", 80'(bus.out_valid_o), 80'(1));
                check("stall_data", pack_out(), prev_val);
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 80'(bus.out_valid_o), 80'(0));
                end else begin
                    check($sformatf("result_%0d", n_out), pack_out(), exp_q.pop_front());
                    n_out++;
                end
            end
            prev_stall = bus.out_valid_o & !bus.out_ready_i;
            prev_val   = pack_out();
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the pair was accepted, in_valid left high.
    task automatic send(input int i);
        bit acc = 1'b0;
        bus.Data_X_i   = vx[i];
        bus.Data_Y_i   = vy[i];
        bus.op_i       = vop[i];
        bus.in_valid_i = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            if (acc) exp_q.push_back(vexp[i]);
            #1;
        end
        if (!acc) check($sformatf("send_timeout_%0d", i), 80'(0), 80'(1));
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        check(tag, 80'(exp_q.size()), 80'(0));
    endtask

    initial begin
        int base_out, base_stall, base_nr;

        vx[0] = 32'h3F800000; vy[0] = 32'h40000000; vop[0] = 1'b0;
        vexp[0] = mk(0, 0, 0, 8'h80, 8'h01, 24'h800000, 24'h800000, 0, 0, 0);
        vx[1] = 32'h40400000; vy[1] = 32'h3F800000; vop[1] = 1'b1;
        vexp[1] = mk(0, 1, 1, 8'h80, 8'h01, 24'hC00000, 24'h800000, 0, 0, 0);
        vx[2] = 32'h3F800000; vy[2] = 32'h40400000; vop[2] = 1'b1;
        vexp[2] = mk(1, 1, 0, 8'h80, 8'h01, 24'hC00000, 24'h800000, 0, 0, 0);
        vx[3] = 32'h7F800000; vy[3] = 32'h7F800000; vop[3] = 1'b1;
        vexp[3] = mk(0, 1, 1, 8'hFF, 8'h00, 24'h800000, 24'h800000, 0, 0, 1);
        vx[4] = 32'h7F800000; vy[4] = 32'h7F800000; vop[4] = 1'b0;
        vexp[4] = mk(0, 0, 1, 8'hFF, 8'h00, 24'h800000, 24'h800000, 0, 1, 0);
        vx[5] = 32'h7FC00000; vy[5] = 32'h3F800000; vop[5] = 1'b0;
        vexp[5] = mk(0, 0, 1, 8'hFF, 8'h80, 24'hC00000, 24'h800000, 0, 0, 1);
        vx[6] = 32'h00000001; vy[6] = 32'h80000000; vop[6] = 1'b0;
        vexp[6] = mk(0, 1, 1, 8'h00, 8'h00, 24'h000000, 24'h000000, 1, 0, 0);
        vx[7] = 32'hC0A00000; vy[7] = 32'h3F000000; vop[7] = 1'b0;
        vexp[7] = mk(1, 1, 1, 8'h81, 8'h03, 24'hA00000, 24'h800000, 0, 0, 0);

        bus.in_valid_i  = 1'b0;
        bus.op_i        = 1'b0;
        bus.Data_X_i    = '0;
        bus.Data_Y_i    = '0;
        bus.out_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 80'(bus.out_valid_o), 80'(0));
        check("rst_in_ready", 80'(bus.in_ready_o), 80'(1));
        check("rst_data", pack_out(), 80'(0));

        // Two-cycle latency for a single pair.
        @(posedge clk); #1;
        bus.Data_X_i = vx[0]; bus.Data_Y_i = vy[0]; bus.op_i = vop[0];
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        check("lat_in_ready", 80'(bus.in_ready_o), 80'(1));
        @(posedge clk);
        exp_q.push_back(vexp[0]);
        #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", 80'(bus.out_valid_o), 80'(0));
        @(negedge clk);
        check("lat_cycle2_valid", 80'(bus.out_valid_o), 80'(1));
        drain("drain_single");

        // Back-to-back directed vectors, no stall.
        @(posedge clk); #1;
        base_out = n_out;
        for (int i = 1; i < 8; i++) send(i);
        bus.in_valid_i = 1'b0;
        drain("drain_stream");
        check("stream_count", 80'(n_out - base_out), 80'(7));

        // Four pairs with out_ready low for four cycles mid-stream.
        @(posedge clk); #1;
        base_out   = n_out;
        base_stall = n_stall;
        base_nr    = n_not_ready;
        fork
            begin
                send(1); send(3); send(5); send(7);
                bus.in_valid_i = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready_i = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready_i = 1'b1;
            end
        join
        drain("drain_stall");
        check("stall_count", 80'(n_out - base_out), 80'(4));
        check("stall_seen", 80'(n_stall > base_stall), 80'(1));
        check("in_ready_dropped", 80'(n_not_ready > base_nr), 80'(1));

        // Reset with two pairs in flight.
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        send(0); send(6);
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 80'(bus.out_valid_o), 80'(0));
        check("midrst_data", pack_out(), 80'(0));
        check("midrst_in_ready", 80'(bus.in_ready_o), 80'(1));
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.out_ready_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check($sformatf("no_stale_%0d", t), 80'(bus.out_valid_o), 80'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
